// File: rtl/stage_execute_vec.sv
// -----------------------------------------------------------------------------
// stage_execute_vec
//   Lane-generic vector/scalar execute stage with an EX/MEM pipeline register.
//   It forwards operands, runs a lane-parallel single-cycle ALU, and handles
//   multiplies with a lane-serial multiplier (one lane product per cycle).
//   While a multiply is in progress, ex_busy tells the front end to hold the
//   EX inputs.
//
// Handshake: ex_busy is a combinational "not ready" indication for the
//   instruction in EX. EX inputs advance only on an edge where ex_busy is 0.
//   A multiply is accepted on the edge out of IDLE. Its result lands on the
//   last-lane edge, and ex_busy is already 0 during that final cycle, so the
//   next instruction may be presented right after that edge.
//
// Ports
//   clk, reset (async, active-low)     clock / reset
//   mem_clear, mem_stall               EX/MEM flush / hold
//   ex_*                               decoded instruction and operands in EX
//   wb_result                          writeback forwarding source
//   ex_busy                            multiply occupies EX
//   mem_*                              EX/MEM register outputs
//   dbg_state                          FSM state (0 idle, 1 multiplying)
// -----------------------------------------------------------------------------
module stage_execute_vec #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  localparam int VLEN  = LANES * LANE_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_clear,
  input  logic            mem_stall,
  input  logic            ex_valid,
  input  logic            ex_reg_write,
  input  logic            ex_mem_write,
  input  logic            ex_mem_read,
  input  logic            ex_vector_op,
  input  logic [1:0]      ex_result_src,
  input  logic [3:0]      ex_alu_control,
  input  logic            ex_alu_src_op2,
  input  logic [31:0]     ex_imm_ext,
  input  logic [31:0]     ex_pc_plus_4,
  input  logic [VLEN-1:0] ex_rd1,
  input  logic [VLEN-1:0] ex_rd2,
  input  logic [4:0]      ex_rd,
  input  logic [VLEN-1:0] wb_result,
  input  logic [1:0]      ex_op1_forward,
  input  logic [1:0]      ex_op2_forward,
  output logic            ex_busy,
  output logic            mem_valid,
  output logic            mem_reg_write,
  output logic            mem_mem_write,
  output logic            mem_mem_read,
  output logic            mem_vector_op,
  output logic [1:0]      mem_result_src,
  output logic [4:0]      mem_rd,
  output logic [31:0]     mem_pc_plus_4,
  output logic [31:0]     mem_imm_ext,
  output logic [VLEN-1:0] mem_alu_result,
  output logic [VLEN-1:0] mem_write_data,
  output logic            dbg_state
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW = (LANE_W > 1) ? $clog2(LANE_W) : 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;
  typedef enum logic { S_IDLE = 1'b0, S_MUL = 1'b1 } state_t;

  // Everything the EX/MEM register carries. An all-zero value is a bubble.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        vector_op;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] pc_plus_4;
    logic [31:0] imm_ext;
    vec_t        alu_result;
    vec_t        write_data;
  } exmem_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  vec_t           a_q, a_d, b_q, b_d;
  exmem_t         cap_q, cap_d;     // captured multiply; alu_result accumulates products
  exmem_t         exmem_q, exmem_d;

  vec_t           op1_fwd, op2_fwd, opb, alu_res;
  logic signed [31:0]  imm_s;
  logic [LANE_W-1:0]   imm_lane;
  logic [LANE_W-1:0]   lane_prod;
  logic                issue_mul;
  logic                last;
  exmem_t              ex_fields;

  // Operand forwarding
  always_comb begin
    case (ex_op1_forward)
      2'b01:   op1_fwd = wb_result;
      2'b10:   op1_fwd = exmem_q.alu_result;
      default: op1_fwd = ex_rd1;
    endcase
    case (ex_op2_forward)
      2'b01:   op2_fwd = wb_result;
      2'b10:   op2_fwd = exmem_q.alu_result;
      default: op2_fwd = ex_rd2;
    endcase
  end

  // Immediate is sign-extended (or truncated) to one lane and broadcast.
  assign imm_s    = ex_imm_ext;
  assign imm_lane = LANE_W'(imm_s);
  assign opb      = ex_alu_src_op2 ? vec_t'({LANES{imm_lane}}) : op2_fwd;

  function automatic logic [LANE_W-1:0] alu_lane(input logic [3:0] op,
                                                 input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return $signed(a) >>> sh;
      OP_SLT:  return LANE_W'($signed(a) < $signed(b));
      default: return '0;   // multiply goes through the lane-serial path
    endcase
  endfunction

  // Scalar ops compute lane 0 only; upper lanes read as zero.
  always_comb begin
    alu_res = '0;
    for (int l = 0; l < LANES; l++) begin
      if (ex_vector_op || (l == 0)) alu_res[l] = alu_lane(ex_alu_control, op1_fwd[l], opb[l]);
    end
  end

  always_comb begin
    ex_fields            = '0;
    ex_fields.valid      = 1'b1;
    ex_fields.reg_write  = ex_reg_write;
    ex_fields.mem_write  = ex_mem_write;
    ex_fields.mem_read   = ex_mem_read;
    ex_fields.vector_op  = ex_vector_op;
    ex_fields.result_src = ex_result_src;
    ex_fields.rd         = ex_rd;
    ex_fields.pc_plus_4  = ex_pc_plus_4;
    ex_fields.imm_ext    = ex_imm_ext;
    ex_fields.alu_result = alu_res;
    ex_fields.write_data = op2_fwd;
  end

  assign issue_mul = ex_valid && (ex_alu_control == OP_MUL);
  assign lane_prod = a_q[cnt_q] * b_q[cnt_q];
  // A scalar multiply finishes on its first lane.
  assign last      = !cap_q.vector_op || (cnt_q == CW'(LANES - 1));

  // Next-state / EX/MEM load
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cap_d   = cap_q;
    exmem_d = exmem_q;
    if (mem_clear) begin
      exmem_d = '0;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (!mem_stall) begin
      case (state_q)
        S_IDLE: begin
          if (issue_mul) begin
            a_d              = op1_fwd;
            b_d              = opb;
            cap_d            = ex_fields;
            cap_d.alu_result = '0;
            cnt_d            = '0;
            state_d          = S_MUL;
            exmem_d          = '0;
          end else if (ex_valid) begin
            exmem_d = ex_fields;
          end else begin
            exmem_d = '0;
          end
        end
        S_MUL: begin
          cap_d.alu_result[cnt_q] = lane_prod;
          if (last) begin
            exmem_d = cap_d;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            exmem_d = '0;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          exmem_d = '0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cap_q   <= '0;
      exmem_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cap_q   <= cap_d;
      exmem_q <= exmem_d;
    end
  end

  assign ex_busy = reset && (((state_q == S_IDLE) && issue_mul) ||
                             ((state_q == S_MUL) && !last));

  assign mem_valid      = exmem_q.valid;
  assign mem_reg_write  = exmem_q.reg_write;
  assign mem_mem_write  = exmem_q.mem_write;
  assign mem_mem_read   = exmem_q.mem_read;
  assign mem_vector_op  = exmem_q.vector_op;
  assign mem_result_src = exmem_q.result_src;
  assign mem_rd         = exmem_q.rd;
  assign mem_pc_plus_4  = exmem_q.pc_plus_4;
  assign mem_imm_ext    = exmem_q.imm_ext;
  assign mem_alu_result = exmem_q.alu_result;
  assign mem_write_data = exmem_q.write_data;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_stage_execute_vec.sv
// -----------------------------------------------------------------------------
// tb_stage_execute_vec
//   Bench for stage_execute_vec with LANES=4, LANE_W=32: a vector table, hand
//   sequences for reset/multiply/stall/clear, and randomized operations
//   checked against a lane-wise arithmetic model.
// -----------------------------------------------------------------------------
module tb_stage_execute_vec;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int VLEN   = LANES * LANE_W;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_clear, mem_stall, ex_valid;
  logic            ex_reg_write, ex_mem_write, ex_mem_read, ex_vector_op;
  logic [1:0]      ex_result_src;
  logic [3:0]      ex_alu_control;
  logic            ex_alu_src_op2;
  logic [31:0]     ex_imm_ext, ex_pc_plus_4;
  logic [VLEN-1:0] ex_rd1, ex_rd2, wb_result;
  logic [4:0]      ex_rd;
  logic [1:0]      ex_op1_forward, ex_op2_forward;
  logic            ex_busy, mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op;
  logic [1:0]      mem_result_src;
  logic [4:0]      mem_rd;
  logic [31:0]     mem_pc_plus_4, mem_imm_ext;
  logic [VLEN-1:0] mem_alu_result, mem_write_data;
  logic            dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [VLEN-1:0] exp_q[$];
  logic [VLEN-1:0] model_last;

  stage_execute_vec #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk), .reset(reset), .mem_clear(mem_clear), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_vector_op(ex_vector_op), .ex_result_src(ex_result_src),
    .ex_alu_control(ex_alu_control), .ex_alu_src_op2(ex_alu_src_op2),
    .ex_imm_ext(ex_imm_ext), .ex_pc_plus_4(ex_pc_plus_4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_rd(ex_rd), .wb_result(wb_result), .ex_op1_forward(ex_op1_forward),
    .ex_op2_forward(ex_op2_forward), .ex_busy(ex_busy), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
    .mem_vector_op(mem_vector_op), .mem_result_src(mem_result_src), .mem_rd(mem_rd),
    .mem_pc_plus_4(mem_pc_plus_4), .mem_imm_ext(mem_imm_ext), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [VLEN-1:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [VLEN-1:0] bcast(input logic [31:0] v);
    return {LANES{v}};
  endfunction

  // Lane-wise reference: plain 64-bit arithmetic, reduced modulo 2^32.
  function automatic logic [VLEN-1:0] model_exec(input logic [3:0] op, input logic vec,
                                                 input logic [VLEN-1:0] a, b);
    logic [VLEN-1:0]  r;
    longint unsigned  x, y, z;
    int               sh;
    r = '0;
    for (int l = 0; l < (vec ? LANES : 1); l++) begin
      x  = a[l*32 +: 32];
      y  = b[l*32 +: 32];
      sh = int'(y % 32);
      case (op)
        4'd0: z = x + y;
        4'd1: z = x - y;
        4'd2: z = x & y;
        4'd3: z = x | y;
        4'd4: z = x ^ y;
        4'd5: z = x << sh;
        4'd6: z = x >> sh;
        4'd7: z = (x >> sh) | ((x >= 64'h8000_0000) ? (((64'd1 << sh) - 1) << (32 - sh)) : 64'd0);
        4'd8: z = (int'(x) < int'(y)) ? 64'd1 : 64'd0;
        4'd9: z = x * y;
        default: z = 0;
      endcase
      r[l*32 +: 32] = z[31:0];
    end
    return r;
  endfunction

  function automatic logic [VLEN-1:0] ctl_act();
    return {mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op,
            mem_result_src, mem_rd, mem_pc_plus_4, mem_imm_ext};
  endfunction

  function automatic logic [VLEN-1:0] ctl_exp();
    return {1'b1, ex_reg_write, ex_mem_write, ex_mem_read, ex_vector_op,
            ex_result_src, ex_rd, ex_pc_plus_4, ex_imm_ext};
  endfunction

  task automatic check(input string name, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_bubble(input string name);
    check({name, " ctl"}, ctl_act(), '0);
    check({name, " res"}, mem_alu_result, '0);
    check({name, " wd"}, mem_write_data, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    mem_clear = 0; mem_stall = 0; ex_valid = 0;
    ex_reg_write = 0; ex_mem_write = 0; ex_mem_read = 0; ex_vector_op = 0;
    ex_result_src = 0; ex_alu_control = 0; ex_alu_src_op2 = 0;
    ex_imm_ext = 0; ex_pc_plus_4 = 0; ex_rd1 = 0; ex_rd2 = 0; ex_rd = 0;
    wb_result = 0; ex_op1_forward = 0; ex_op2_forward = 0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic vec, input logic src_imm,
                        input logic [VLEN-1:0] rd1, input logic [VLEN-1:0] rd2,
                        input logic [31:0] imm);
    ex_valid = 1; ex_alu_control = op; ex_vector_op = vec; ex_alu_src_op2 = src_imm;
    ex_rd1 = rd1; ex_rd2 = rd2; ex_imm_ext = imm;
    ex_op1_forward = 2'b00; ex_op2_forward = 2'b00;
    ex_reg_write  = 1'($urandom_range(0, 1));
    ex_mem_write  = 1'($urandom_range(0, 1));
    ex_mem_read   = 1'($urandom_range(0, 1));
    ex_result_src = 2'($urandom_range(0, 3));
    ex_rd         = 5'($urandom_range(0, 31));
    ex_pc_plus_4  = $urandom;
  endtask

  // Issues a multiply and follows it to its result. stall_at is the edge
  // count after which mem_stall rises for stall_len edges (-1: none).
  task automatic run_mul(input string name, input logic vec,
                         input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                         input int stall_at, input int stall_len, input logic wb_poke);
    int edges, busy_cycles, exp_edges, exp_busy;
    logic [VLEN-1:0] exp;
    exp = model_exec(4'd9, vec, a, b);
    set_op(4'b1001, vec, 1'b0, wb_poke ? ~a : a, b, 32'h0);
    if (wb_poke) begin
      ex_op1_forward = 2'b01;
      wb_result      = a;
    end
    exp_edges = (vec ? LANES : 1) + 1 + ((stall_at >= 0) ? stall_len : 0);
    exp_busy  = (vec ? LANES : 1) + ((stall_at >= 0) ? stall_len : 0);
    edges = 0;
    busy_cycles = 0;
    while (edges < 40) begin
      #1;
      if (ex_busy) busy_cycles++;
      @(posedge clk);
      #1;
      edges++;
      if (wb_poke && edges == 1) wb_result = ~a;
      if (stall_at >= 0 && edges == stall_at) mem_stall = 1;
      if (stall_at >= 0 && edges == stall_at + stall_len) mem_stall = 0;
      if (mem_valid) break;
    end
    mem_stall = 0;
    check({name, " edges"}, VLEN'(edges), VLEN'(exp_edges));
    check({name, " busy cycles"}, VLEN'(busy_cycles), VLEN'(exp_busy));
    check({name, " result"}, mem_alu_result, exp);
    check({name, " wdata"}, mem_write_data, b);
    check({name, " ctl"}, ctl_act(), ctl_exp());
    ex_valid = 0;
    model_last = exp;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]      op;
    logic            vec;
    logic            src_imm;
    logic [VLEN-1:0] rd1;
    logic [VLEN-1:0] rd2;
    logic [31:0]     imm;
    logic [VLEN-1:0] exp_res;
  } vec_rec_t;

  vec_rec_t tbl[$];

  task automatic add_vec(input logic [3:0] op, input logic vec, input logic src_imm,
                         input logic [VLEN-1:0] rd1, input logic [VLEN-1:0] rd2,
                         input logic [31:0] imm, input logic [VLEN-1:0] exp_res);
    vec_rec_t r;
    r.op = op; r.vec = vec; r.src_imm = src_imm; r.rd1 = rd1; r.rd2 = rd2;
    r.imm = imm; r.exp_res = exp_res;
    tbl.push_back(r);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [VLEN-1:0] a, b, op1, op2, wd_exp;
    logic [3:0]      op;
    logic            vec, src;

    add_vec(4'd0, 0, 1, pack4(5, 9, 9, 9), pack4(100, 200, 300, 400), 32'hFFFFFFFF, pack4(4, 0, 0, 0));
    add_vec(4'd1, 1, 0, pack4(10, 0, 5, 7), pack4(3, 1, 5, 8), 0, pack4(7, 32'hFFFFFFFF, 0, 32'hFFFFFFFF));
    add_vec(4'd2, 1, 0, pack4(32'hF0F0F0F0, 32'hFFFFFFFF, 0, 32'h12345678),
            pack4(32'hFF00FF00, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0F0F0F0F), 0,
            pack4(32'hF000F000, 32'h0000FFFF, 0, 32'h02040608));
    add_vec(4'd3, 1, 0, pack4(1, 2, 0, 32'h80000000), pack4(2, 2, 0, 1), 0, pack4(3, 2, 0, 32'h80000001));
    add_vec(4'd4, 1, 0, pack4(32'hFFFFFFFF, 32'hA5A5A5A5, 0, 1), pack4(32'h0F0F0F0F, 32'h5A5A5A5A, 0, 1), 0,
            pack4(32'hF0F0F0F0, 32'hFFFFFFFF, 0, 0));
    add_vec(4'd5, 1, 0, pack4(1, 1, 3, 32'hFFFFFFFF), pack4(0, 31, 4, 33), 0,
            pack4(1, 32'h80000000, 32'h30, 32'hFFFFFFFE));
    add_vec(4'd6, 1, 0, pack4(32'h80000000, 32'hFFFFFFFF, 32'h10, 1), pack4(4, 31, 36, 0), 0,
            pack4(32'h08000000, 1, 1, 1));
    add_vec(4'd7, 1, 0, pack4(32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF0, 32'h80000000), pack4(4, 4, 2, 31), 0,
            pack4(32'hF8000000, 32'h07FFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFF));
    add_vec(4'd8, 1, 0, pack4(32'hFFFFFFFF, 1, 5, 32'h80000000), pack4(1, 32'hFFFFFFFF, 5, 32'h7FFFFFFF), 0,
            pack4(1, 0, 0, 1));
    add_vec(4'd8, 0, 1, pack4(32'hFFFFFFFE, 7, 7, 7), pack4(9, 9, 9, 9), 32'hFFFFFFFF, pack4(1, 0, 0, 0));
    add_vec(4'd10, 1, 0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, '0);
    add_vec(4'd15, 1, 0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, '0);
    add_vec(4'd0, 0, 0, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 0, pack4(3, 0, 0, 0));
    add_vec(4'd0, 1, 1, pack4(16, 0, 20, 5), pack4(0, 0, 0, 0), 32'hFFFFFFF0,
            pack4(0, 32'hFFFFFFF0, 4, 32'hFFFFFFF5));

    // ---- reset: a multiply presented while reset is low does not raise busy
    drive_idle();
    reset = 1'b1;
    #1 reset = 1'b0;
    ex_valid = 1; ex_alu_control = 4'b1001;
    #2;
    check("reset busy", VLEN'(ex_busy), '0);
    check_bubble("reset");
    step();
    step();
    check_bubble("reset held");
    check("reset state", VLEN'(dbg_state), '0);

    // ---- reset mid vector multiply (cnt = 2)
    reset = 1'b1;
    set_op(4'b1001, 1, 0, pack4(2, 3, 4, 32'hFFFFFFFF), pack4(5, 6, 7, 2), 0);
    step(); step(); step();
    check("mid-mul state", VLEN'(dbg_state), VLEN'(1));
    check("mid-mul busy", VLEN'(ex_busy), VLEN'(1));
    #2 reset = 1'b0;
    #1;
    check("async reset busy", VLEN'(ex_busy), '0);
    check("async reset state", VLEN'(dbg_state), '0);
    check_bubble("async reset");
    set_op(4'd0, 1, 0, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 0);
    reset = 1'b1;
    step();
    check("post-reset add", mem_alu_result, pack4(11, 22, 33, 44));
    check("post-reset ctl", ctl_act(), ctl_exp());

    // ---- table vectors
    foreach (tbl[i]) begin
      set_op(tbl[i].op, tbl[i].vec, tbl[i].src_imm, tbl[i].rd1, tbl[i].rd2, tbl[i].imm);
      step();
      check($sformatf("tbl%0d res", i), mem_alu_result, tbl[i].exp_res);
      check($sformatf("tbl%0d wd", i), mem_write_data, tbl[i].rd2);
      check($sformatf("tbl%0d ctl", i), ctl_act(), ctl_exp());
    end

    // ---- forwarding
    set_op(4'd0, 1, 0, bcast(99), bcast(1), 0);
    ex_op1_forward = 2'b01; wb_result = bcast(7);
    step();
    check("fwd wb add", mem_alu_result, bcast(8));
    set_op(4'd1, 1, 1, bcast(99), bcast(0), 3);
    ex_op1_forward = 2'b10;
    step();
    check("fwd mem sub", mem_alu_result, bcast(5));
    set_op(4'd0, 1, 0, bcast(1), bcast(99), 0);
    ex_op2_forward = 2'b10;
    step();
    check("fwd2 mem add", mem_alu_result, bcast(6));
    check("fwd2 mem wd", mem_write_data, bcast(5));
    set_op(4'd0, 1, 0, bcast(2), bcast(99), 0);
    ex_op1_forward = 2'b11; ex_op2_forward = 2'b01; wb_result = bcast(7);
    step();
    check("fwd11/01 add", mem_alu_result, bcast(9));
    check("fwd11/01 wd", mem_write_data, bcast(7));

    // ---- stall and clear on single-cycle ops
    set_op(4'd0, 1, 0, bcast(100), bcast(1), 0);
    mem_stall = 1;
    step();
    check("stall hold", mem_alu_result, bcast(9));
    mem_stall = 0;
    step();
    check("stall release", mem_alu_result, bcast(101));
    mem_clear = 1;
    step();
    check_bubble("clear single");
    mem_clear = 0;

    // ---- multiplies
    run_mul("vmul", 1, pack4(2, 3, 4, 32'hFFFFFFFF), pack4(5, 6, 7, 2), -1, 0, 0);
    check("vmul lanes", mem_alu_result, pack4(10, 18, 28, 32'hFFFFFFFE));
    run_mul("smul", 0, pack4(6, 3, 3, 3), pack4(7, 3, 3, 3), -1, 0, 0);
    check("smul 42", mem_alu_result, pack4(42, 0, 0, 0));
    run_mul("vmul stall", 1, pack4(2, 3, 4, 32'hFFFFFFFF), pack4(5, 6, 7, 2), 2, 2, 1);

    // ---- clear mid vector multiply (cnt = 2)
    set_op(4'b1001, 1, 0, pack4(2, 3, 4, 5), pack4(5, 6, 7, 8), 0);
    step(); step(); step();
    mem_clear = 1; ex_valid = 0;
    step();
    mem_clear = 0;
    #1;
    check_bubble("clear mul");
    check("clear mul state", VLEN'(dbg_state), '0);
    check("clear mul busy", VLEN'(ex_busy), '0);
    set_op(4'd7, 0, 1, pack4(32'h80000000, 1, 1, 1), bcast(0), 4);
    step();
    check("sra after clear", mem_alu_result, pack4(32'hF8000000, 0, 0, 0));
    set_op(4'd8, 0, 0, pack4(32'hFFFFFFFF, 0, 0, 0), pack4(1, 0, 0, 0), 0);
    step();
    check("slt -1<1", mem_alu_result, pack4(1, 0, 0, 0));
    model_last = pack4(1, 0, 0, 0);

    // ---- randomized operations against the model
    for (int it = 0; it < 80; it++) begin
      op  = 4'($urandom_range(0, 15));
      vec = 1'($urandom_range(0, 1));
      src = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom, $urandom, $urandom};
      b   = {$urandom, $urandom, $urandom, $urandom};
      if (op == 4'd9) begin
        run_mul($sformatf("rnd%0d mul", it), vec, a, b, -1, 0, 0);
      end else begin
        set_op(op, vec, src, a, b, $urandom);
        ex_op1_forward = 2'($urandom_range(0, 3));
        ex_op2_forward = 2'($urandom_range(0, 3));
        wb_result      = {$urandom, $urandom, $urandom, $urandom};
        ex_valid       = ($urandom_range(0, 7) != 0);
        op1 = (ex_op1_forward == 2'b01) ? wb_result : (ex_op1_forward == 2'b10) ? model_last : a;
        op2 = (ex_op2_forward == 2'b01) ? wb_result : (ex_op2_forward == 2'b10) ? model_last : b;
        wd_exp = ex_valid ? op2 : '0;
        if (src) op2 = bcast(ex_imm_ext);
        exp_q.push_back(ex_valid ? model_exec(op, vec, op1, op2) : '0);
        step();
        model_last = exp_q.pop_front();
        check($sformatf("rnd%0d res", it), mem_alu_result, model_last);
        check($sformatf("rnd%0d wd", it), mem_write_data, wd_exp);
        check($sformatf("rnd%0d ctl", it), ctl_act(), ex_valid ? ctl_exp() : '0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
